// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and a 2-entry LSU result FIFO onto one register-file write port, with a pending-destination scoreboard.
// Latency: ALU result in N -> write in N+1; LSU accept in N -> earliest write in N+2 (+1 per cycle of ALU activity).
// Backpressure: lsu_ready and alu_stall come only from the registered FIFO count; the ALU always wins arbitration, even while stalled.
module wb_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_waddr,
    input  logic [DW-1:0]     alu_data,
    output logic              alu_stall,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [AW-1:0]     lsu_waddr,
    input  logic [DW-1:0]     lsu_data,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_waddr,
    output logic [2**AW-1:0]  busy,
    output logic              wen,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     win
);

    localparam int NR = 2**AW;

    // FIFO state: two {waddr, data} slots, 1-bit pointers, occupancy 0..2
    logic [AW-1:0] r_fifo_waddr [2];
    logic [DW-1:0] r_fifo_data  [2];
    logic          r_rd_ptr;
    logic          r_wr_ptr;
    logic [1:0]    r_count;

    logic [NR-1:0] r_busy;
    logic          r_wen;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_win;

    logic          w_push;
    logic          w_pop;
    logic          w_sel_vld;
    logic [AW-1:0] w_sel_waddr;
    logic [DW-1:0] w_sel_data;
    logic [AW-1:0] w_head_waddr;
    logic [DW-1:0] w_head_data;
    logic [1:0]    w_count_nxt;
    logic [NR-1:0] w_busy_nxt;

    // Flow-control flags depend on the registered count only, so the pop
    // decision can never feed back into lsu_ready within a cycle.
    assign lsu_ready    = (r_count != 2'd2);
    assign alu_stall    = (r_count == 2'd2);
    assign w_push       = lsu_valid && lsu_ready;
    assign w_head_waddr = r_fifo_waddr[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];

    assign busy  = r_busy;
    assign wen   = r_wen;
    assign waddr = r_waddr;
    assign win   = r_win;

    // Arbitration: ALU first, else pop the FIFO head; no bypass from push to pop
    always_comb begin
        w_pop       = 1'b0;
        w_sel_vld   = 1'b0;
        w_sel_waddr = alu_waddr;
        w_sel_data  = alu_data;
        if (alu_valid) begin
            w_sel_vld = 1'b1;
        end else if (r_count != 2'd0) begin
            w_pop       = 1'b1;
            w_sel_vld   = 1'b1;
            w_sel_waddr = w_head_waddr;
            w_sel_data  = w_head_data;
        end
    end

    // Next occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Scoreboard update: clear on pop first so a same-cycle issue to that register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_waddr] = 1'b0;
        end
        if (issue_valid && (issue_waddr != '0)) begin
            w_busy_nxt[issue_waddr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // FIFO control state and scoreboard, discarded wholesale on reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_busy   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // FIFO payload slots; contents are meaningless unless counted, so no reset
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_fifo_waddr[r_wr_ptr] <= lsu_waddr;
            r_fifo_data[r_wr_ptr]  <= lsu_data;
        end
    end

    // Write-port register: r0 targets are consumed silently, idle cycles hold address/data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_win   <= '0;
        end else begin
            r_wen <= w_sel_vld && (w_sel_waddr != '0);
            if (w_sel_vld) begin
                r_waddr <= w_sel_waddr;
                r_win   <= w_sel_data;
            end
        end
    end

endmodule
